// File: rtl/router_pkt_fifo_if.sv
// router_pkt_fifo_if: write/read handshake and status bundle for one router output FIFO
interface router_pkt_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);
    logic              we;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              re;
    logic [DATA_W:0]   data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AW:0]       level;
    logic              pkt_active;
    logic              pkt_done;
    logic              err_ovf;
    logic              err_udf;
    logic              err_frame;
    modport master (
        output we, lfd_state, data_in, re,
        input  data_out, full, empty, almost_full, almost_empty, level,
               pkt_active, pkt_done, err_ovf, err_udf, err_frame
    );
    modport slave (
        input  we, lfd_state, data_in, re,
        output data_out, full, empty, almost_full, almost_empty, level,
               pkt_active, pkt_done, err_ovf, err_udf, err_frame
    );
endinterface

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware synchronous FIFO with level, threshold, framing and overflow reporting
module router_pkt_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int LEN_LSB = 2,
    parameter int LEN_W   = 6,
    parameter int AF_THR  = DEPTH - 2,
    parameter int AE_THR  = 2
) (
    input logic               clk,
    input logic               rst,
    input logic               soft_rst,
    router_pkt_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_V = AF_THR[AW:0];
    localparam logic [AW:0] AE_V = AE_THR[AW:0];
    localparam logic [LEN_W:0] REM_ONE = {{LEN_W{1'b0}}, 1'b1};
    logic [DATA_W:0]  mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [LEN_W:0]   rem, rem_nxt;
    logic [DATA_W:0]  rd_word;
    logic             wr, rd, hdr;
    assign bus.full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign bus.empty        = wr_ptr == rd_ptr;
    assign bus.level        = wr_ptr - rd_ptr;
    assign bus.almost_full  = bus.level >= AF_V;
    assign bus.almost_empty = bus.level <= AE_V;
    assign bus.pkt_active   = |rem;
    assign wr      = bus.we && !bus.full;
    assign rd      = bus.re && !bus.empty;
    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign hdr     = rd_word[DATA_W];
    // a header reloads payload length plus the trailing parity byte; stray bytes leave rem at 0
    assign rem_nxt = !rd ? rem :
                     hdr ? {1'b0, rd_word[LEN_LSB +: LEN_W]} + 1'b1 :
                     |rem ? rem - 1'b1 : rem;
    always_ff @(posedge clk)
        if (wr && !soft_rst) mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rem           <= '0;
            bus.data_out  <= '0;
            bus.pkt_done  <= 1'b0;
            bus.err_ovf   <= 1'b0;
            bus.err_udf   <= 1'b0;
            bus.err_frame <= 1'b0;
        end else if (soft_rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rem           <= '0;
            bus.data_out  <= '0;
            bus.pkt_done  <= 1'b0;
            bus.err_ovf   <= 1'b0;
            bus.err_udf   <= 1'b0;
            bus.err_frame <= 1'b0;
        end else begin
            wr_ptr        <= wr ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr        <= rd ? rd_ptr + 1'b1 : rd_ptr;
            bus.data_out  <= rd ? rd_word : bus.data_out;
            rem           <= rem_nxt;
            bus.pkt_done  <= rd && !hdr && (rem == REM_ONE);
            bus.err_ovf   <= bus.err_ovf | (bus.we && bus.full);
            bus.err_udf   <= bus.err_udf | (bus.re && bus.empty);
            bus.err_frame <= bus.err_frame | (rd && hdr && |rem);
        end
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo: directed scoreboard bench for router_pkt_fifo
module tb_router_pkt_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic soft_rst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [8:0] mq[$];
    int mrem;
    logic [8:0] mdout;
    logic mdone, movf, mudf, mfrm;
    always #5 clk = ~clk;
    router_pkt_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();
    router_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .bus(bus)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic mreset();
        mq.delete();
        mrem = 0;
        mdout = '0;
        mdone = 0;
        movf = 0;
        mudf = 0;
        mfrm = 0;
    endtask
    task automatic check_all(input string tag);
        chk({tag, ":level"}, bus.level, mq.size());
        chk({tag, ":full"}, bus.full, mq.size() == DEPTH);
        chk({tag, ":empty"}, bus.empty, mq.size() == 0);
        chk({tag, ":af"}, bus.almost_full, mq.size() >= DEPTH - 2);
        chk({tag, ":ae"}, bus.almost_empty, mq.size() <= 2);
        chk({tag, ":active"}, bus.pkt_active, mrem != 0);
        chk({tag, ":done"}, bus.pkt_done, mdone);
        chk({tag, ":ovf"}, bus.err_ovf, movf);
        chk({tag, ":udf"}, bus.err_udf, mudf);
        chk({tag, ":frame"}, bus.err_frame, mfrm);
        chk({tag, ":dout"}, bus.data_out, mdout);
    endtask
    task automatic step(input string tag, input logic w, input logic h, input logic [7:0] d, input logic r);
        int n;
        logic aw, ar;
        logic [8:0] word;
        bus.we = w;
        bus.lfd_state = h;
        bus.data_in = d;
        bus.re = r;
        n = mq.size();
        aw = w && n < DEPTH;
        ar = r && n > 0;
        movf |= w && n == DEPTH;
        mudf |= r && n == 0;
        mdone = 0;
        if (ar) begin
            word = mq.pop_front();
            mdout = word;
            if (word[8]) begin
                if (mrem != 0) mfrm = 1;
                mrem = int'(word[7:2]) + 1;
            end else if (mrem != 0) begin
                mdone = (mrem == 1);
                mrem--;
            end
        end
        if (aw) mq.push_back({h, d});
        @(posedge clk);
        #1;
        bus.we = 0;
        bus.re = 0;
        check_all(tag);
    endtask
    task automatic do_soft(input string tag);
        soft_rst = 1;
        bus.we = 1;
        bus.lfd_state = 1;
        bus.data_in = 8'h5A;
        bus.re = 1;
        @(posedge clk);
        #1;
        soft_rst = 0;
        bus.we = 0;
        bus.re = 0;
        mreset();
        check_all(tag);
    endtask
    initial begin
        bus.we = 0;
        bus.re = 0;
        bus.lfd_state = 0;
        bus.data_in = '0;
        mreset();
        #12;
        check_all("reset");
        chk("reset_empty", bus.empty, 1);
        @(negedge clk);
        rst = 1;
        // fill to DEPTH, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            step("t1_wr", 1, 0, 8'(8'h10 + i), 0);
            chk("t1_af", bus.almost_full, (i + 1) >= 14);
        end
        chk("t1_full", bus.full, 1);
        chk("t1_level", bus.level, 16);
        step("t1_ovf", 1, 0, 8'hEE, 0);
        chk("t1_ovf_flag", bus.err_ovf, 1);
        chk("t1_ovf_level", bus.level, 16);
        // read+write while full: only the read happens
        step("t3", 1, 0, 8'h77, 1);
        chk("t3_level", bus.level, 15);
        chk("t3_dout", bus.data_out, 9'h010);
        chk("t3_ovf", bus.err_ovf, 1);
        for (int i = 0; i < 15; i++) step("t3_rd", 0, 0, 8'h00, 1);
        chk("t3_last", bus.data_out, 9'h01F);
        step("t3_udf", 0, 0, 8'h00, 1);
        chk("t3_udf_flag", bus.err_udf, 1);
        chk("t3_hold", bus.data_out, 9'h01F);
        do_soft("srst1");
        chk("srst1_ovf", bus.err_ovf, 0);
        // header len=3 followed by 4 bytes
        step("t2_hdr", 1, 1, 8'h0C, 0);
        for (int i = 0; i < 4; i++) step("t2_wr", 1, 0, 8'(8'hA0 + i), 0);
        step("t2_rd1", 0, 0, 8'h00, 1);
        chk("t2_active", bus.pkt_active, 1);
        chk("t2_hdr_out", bus.data_out, 9'h10C);
        for (int i = 0; i < 3; i++) step("t2_rd", 0, 0, 8'h00, 1);
        chk("t2_nodone", bus.pkt_done, 0);
        step("t2_rd5", 0, 0, 8'h00, 1);
        chk("t2_done", bus.pkt_done, 1);
        chk("t2_inactive", bus.pkt_active, 0);
        chk("t2_dout", bus.data_out, 9'h0A3);
        step("t2_idle", 0, 0, 8'h00, 0);
        chk("t2_pulse", bus.pkt_done, 0);
        // streaming at level 1 across pointer wrap
        step("t4_pre", 1, 0, 8'h30, 0);
        for (int i = 0; i < 40; i++) begin
            step("t4", 1, 0, 8'(8'h31 + i), 1);
            chk("t4_level", bus.level, 1);
        end
        step("t4_rd", 0, 0, 8'h00, 1);
        chk("t4_dout", bus.data_out, 9'h058);
        // truncated packet followed by a new header
        step("t5_h1", 1, 1, 8'h10, 0);
        step("t5_b1", 1, 0, 8'h41, 0);
        step("t5_b2", 1, 0, 8'h42, 0);
        step("t5_h2", 1, 1, 8'h08, 0);
        for (int i = 0; i < 3; i++) step("t5_b", 1, 0, 8'(8'h43 + i), 0);
        for (int i = 0; i < 3; i++) step("t5_rd", 0, 0, 8'h00, 1);
        chk("t5_noframe", bus.err_frame, 0);
        step("t5_rdh", 0, 0, 8'h00, 1);
        chk("t5_frame", bus.err_frame, 1);
        chk("t5_active", bus.pkt_active, 1);
        step("t5_rd", 0, 0, 8'h00, 1);
        step("t5_rd", 0, 0, 8'h00, 1);
        step("t5_rd", 0, 0, 8'h00, 1);
        chk("t5_done", bus.pkt_done, 1);
        // soft reset with a packet in flight
        step("t6_hdr", 1, 1, 8'h14, 0);
        for (int i = 0; i < 7; i++) step("t6_wr", 1, 0, 8'(8'h60 + i), 0);
        step("t6_rd", 0, 0, 8'h00, 1);
        chk("t6_level7", bus.level, 7);
        chk("t6_active", bus.pkt_active, 1);
        do_soft("t6_srst");
        chk("t6_empty", bus.empty, 1);
        chk("t6_level0", bus.level, 0);
        chk("t6_dout0", bus.data_out, 0);
        chk("t6_frame0", bus.err_frame, 0);
        chk("t6_inactive", bus.pkt_active, 0);
        // dirty the state, then async reset mid-cycle
        step("t6_w", 1, 1, 8'h20, 0);
        step("t6_w", 1, 0, 8'h21, 0);
        step("t6_w", 1, 0, 8'h22, 0);
        step("t6_r", 0, 0, 8'h00, 1);
        step("t6_ovr", 0, 0, 8'h00, 1);
        @(posedge clk);
        #3;
        rst = 0;
        #1;
        mreset();
        check_all("arst");
        chk("arst_dout", bus.data_out, 0);
        chk("arst_empty", bus.empty, 1);
        #2;
        rst = 1;
        step("post_arst", 1, 0, 8'h99, 0);
        step("post_arst_rd", 0, 0, 8'h00, 1);
        chk("post_arst_dout", bus.data_out, 9'h099);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
